// File: rtl/mvu_data_loader_if.sv
// ============================================================================
//  Module   : mvu_data_loader_if
//  Brief    : Command, activation stream and MVU write-port bundle for the loader
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mvu_data_loader_if #(
  parameter int NMVU    = 8,
  parameter int N       = 64,
  parameter int BDBANKA = 15,
  parameter int BLEN    = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [NMVU-1:0]     cmd_mask;
  logic [BDBANKA-1:0]  cmd_addr;
  logic [BLEN-1:0]     cmd_len;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        in_word;
  logic [NMVU-1:0]     wrc_en;
  logic [NMVU-1:0]     wrc_grnt;
  logic [BDBANKA-1:0]  wrc_addr;
  logic [N-1:0]        wrc_word;
  logic                busy;
  logic                done;

  modport master (
    output cmd_valid, cmd_mask, cmd_addr, cmd_len, in_valid, in_word, wrc_grnt,
    input  cmd_ready, in_ready, wrc_en, wrc_addr, wrc_word, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_mask, cmd_addr, cmd_len, in_valid, in_word, wrc_grnt,
    output cmd_ready, in_ready, wrc_en, wrc_addr, wrc_word, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/mvu_data_loader.sv
// ============================================================================
//  Module   : mvu_data_loader
//  Brief    : Streams activation words into the data banks of selected MVUs
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mvu_data_loader #(
  parameter int NMVU    = 8,
  parameter int N       = 64,
  parameter int BDBANKA = 15,
  parameter int BLEN    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mvu_data_loader_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_busy;

  logic [NMVU-1:0]     r_mask;
  logic [BDBANKA-1:0]  r_addr;
  logic [BLEN-1:0]     r_len;
  logic [BLEN-1:0]     r_acc_cnt;
  logic [BLEN-1:0]     r_ret_cnt;
  logic                r_buf_v;
  logic [N-1:0]        r_buf_word;
  logic [NMVU-1:0]     r_pend;
  logic [BDBANKA-1:0]  r_wrc_addr;

  logic                w_cmd_hs;
  logic                w_in_hs;
  logic                w_in_ready;
  logic [NMVU-1:0]     w_pend_left;
  logic                w_retire;
  logic                w_last;
  logic [BDBANKA-1:0]  w_addr_inc;
  logic [BLEN-1:0]     w_ret_inc;

  assign w_pend_left = r_pend & ~bus.wrc_grnt;
  assign w_retire    = (r_state == S_LOAD) && r_buf_v && (w_pend_left == '0);
  assign w_ret_inc   = r_ret_cnt + BLEN'(1);
  assign w_last      = w_retire && (w_ret_inc == r_len);
  assign w_addr_inc  = r_addr + BDBANKA'(1);
  assign w_cmd_hs    = bus.cmd_valid && (r_state == S_IDLE);
  // Refill is allowed in the retire cycle so full grants sustain one word per cycle.
  assign w_in_ready  = (r_state == S_LOAD) && (r_acc_cnt < r_len) && (!r_buf_v || w_retire);
  assign w_in_hs     = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_LOAD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if ((bus.cmd_len == '0) || (bus.cmd_mask == '0)) w_state_nxt = S_FIN;
          else                                            w_state_nxt = S_LOAD;
        end
      end
      S_LOAD:  if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (r_state == S_IDLE);
    bus.done      = (r_state == S_FIN);
    bus.in_ready  = w_in_ready;
    bus.wrc_en    = '0;
    if ((r_state == S_LOAD) && r_buf_v) bus.wrc_en = r_pend;
  end

  assign bus.busy     = r_busy;
  assign bus.wrc_addr = r_wrc_addr;
  assign bus.wrc_word = r_buf_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask     <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_acc_cnt  <= '0;
      r_ret_cnt  <= '0;
      r_buf_v    <= 1'b0;
      r_buf_word <= '0;
      r_pend     <= '0;
      r_wrc_addr <= '0;
    end else if (w_cmd_hs) begin
      r_mask    <= bus.cmd_mask;
      r_addr    <= bus.cmd_addr;
      r_len     <= bus.cmd_len;
      r_acc_cnt <= '0;
      r_ret_cnt <= '0;
      r_buf_v   <= 1'b0;
      r_pend    <= '0;
    end else if (r_state == S_LOAD) begin
      // Grants only clear outstanding bits, so no MVU is written twice.
      r_pend <= w_pend_left;
      if (w_retire) begin
        r_ret_cnt <= w_ret_inc;
        r_addr    <= w_addr_inc;
        r_buf_v   <= 1'b0;
      end
      if (w_in_hs) begin
        r_buf_word <= bus.in_word;
        r_buf_v    <= 1'b1;
        r_pend     <= r_mask;
        r_acc_cnt  <= r_acc_cnt + BLEN'(1);
        r_wrc_addr <= w_retire ? w_addr_inc : r_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mvu_data_loader.sv
// ============================================================================
//  Module   : tb_mvu_data_loader
//  Brief    : Directed self-checking bench for mvu_data_loader
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mvu_data_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acc    = 0;

  always #5 clk = ~clk;

  mvu_data_loader_if #(.NMVU(8), .N(64), .BDBANKA(15), .BLEN(16)) bus ();

  mvu_data_loader #(.NMVU(8), .N(64), .BDBANKA(15), .BLEN(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic issue_cmd(input logic [7:0] mask, input logic [14:0] addr, input logic [15:0] len);
    bus.cmd_mask  = mask;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    #1 chk("cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Full-grant stream of len words; called with the loader already in LOAD.
  task automatic stream_load(input logic [14:0] base, input int len, input logic [7:0] mask);
    logic [14:0] ea;
    bus.wrc_grnt = 8'hFF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < len; i++) begin
      bus.in_word = pat(i);
      #1 chk("s_in_ready", bus.in_ready, 1);
      tick();
      if (i == len - 1) bus.in_valid = 1'b0;
      ea = base + 15'(i);
      #1;
      chk("s_wrc_en", bus.wrc_en, mask);
      chk("s_wrc_addr", bus.wrc_addr, ea);
      chk("s_wrc_word", bus.wrc_word, pat(i));
      chk("s_busy", bus.busy, 1);
    end
    chk("s_in_ready_last", bus.in_ready, 0);
    tick();
    chk("s_done", bus.done, 1);
    chk("s_en_fin", bus.wrc_en, 0);
    tick();
    chk("s_done_low", bus.done, 0);
    chk("s_busy_low", bus.busy, 0);
    chk("s_cmd_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_mask  = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.wrc_grnt  = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wrc_en", bus.wrc_en, 0);
    chk("rst_wrc_addr", bus.wrc_addr, 0);
    chk("rst_wrc_word", bus.wrc_word, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    // Basic single-MVU load
    issue_cmd(8'h01, 15'h0010, 16'd4);
    #1 chk("b_cmd_ready_busy", bus.cmd_ready, 0);
    stream_load(15'h0010, 4, 8'h01);

    // Broadcast with staggered grants
    bus.wrc_grnt = 8'h00;
    issue_cmd(8'hFF, 15'h0020, 16'd2);
    bus.in_valid = 1'b1;
    bus.in_word  = 64'h1111_2222_3333_4444;
    #1 chk("g_in_ready0", bus.in_ready, 1);
    tick();
    bus.in_word  = 64'h5555_6666_7777_8888;
    bus.wrc_grnt = 8'h0F;
    #1;
    chk("g_en_c1", bus.wrc_en, 8'hFF);
    chk("g_rdy_c1", bus.in_ready, 0);
    chk("g_word_c1", bus.wrc_word, 64'h1111_2222_3333_4444);
    tick();
    bus.wrc_grnt = 8'h00;
    #1;
    chk("g_en_c2", bus.wrc_en, 8'hF0);
    chk("g_rdy_c2", bus.in_ready, 0);
    tick();
    bus.wrc_grnt = 8'hF0;
    #1;
    chk("g_en_c3", bus.wrc_en, 8'hF0);
    chk("g_rdy_c3", bus.in_ready, 1);
    chk("g_addr_c3", bus.wrc_addr, 15'h0020);
    tick();
    bus.in_valid = 1'b0;
    bus.wrc_grnt = 8'hFF;
    #1;
    chk("g_en_w1", bus.wrc_en, 8'hFF);
    chk("g_addr_w1", bus.wrc_addr, 15'h0021);
    chk("g_word_w1", bus.wrc_word, 64'h5555_6666_7777_8888);
    chk("g_rdy_w1", bus.in_ready, 0);
    tick();
    chk("g_done", bus.done, 1);
    tick();

    // Address wrap
    issue_cmd(8'h01, 15'h7FFE, 16'd3);
    stream_load(15'h7FFE, 3, 8'h01);

    // Zero-length and zero-mask commands
    bus.in_valid = 1'b1;
    issue_cmd(8'h01, 15'h0000, 16'd0);
    #1;
    chk("z0_done", bus.done, 1);
    chk("z0_en", bus.wrc_en, 0);
    chk("z0_rdy", bus.in_ready, 0);
    tick();
    chk("z0_done_low", bus.done, 0);
    issue_cmd(8'h00, 15'h0000, 16'd5);
    #1;
    chk("z1_done", bus.done, 1);
    chk("z1_en", bus.wrc_en, 0);
    chk("z1_rdy", bus.in_ready, 0);
    tick();
    chk("z1_done_low", bus.done, 0);

    // Back-pressure with continuous in_valid; in_valid high through IDLE too
    bus.wrc_grnt = 8'h00;
    bus.in_word  = 64'hAAAA_0000_0000_0000;
    issue_cmd(8'h01, 15'h0030, 16'd2);
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (bus.in_valid && bus.in_ready) n_acc++;
      if (c >= 1 && c <= 10) begin
        chk("bp_rdy_low", bus.in_ready, 0);
        chk("bp_hold_word", bus.wrc_word, 64'hAAAA_0000_0000_0000);
      end
      tick();
      if (n_acc == 1) bus.in_word = 64'hBBBB_0000_0000_0000;
      if (n_acc == 2) bus.in_word = 64'hCCCC_0000_0000_0000;
      if (c == 10) bus.wrc_grnt = 8'h01;
    end
    chk("bp_accepted", 64'(n_acc), 2);
    chk("bp_last_word", bus.wrc_word, 64'hBBBB_0000_0000_0000);
    chk("bp_idle", bus.cmd_ready, 1);
    bus.in_valid = 1'b0;

    // Reset in the middle of a load
    issue_cmd(8'h01, 15'h0040, 16'd5);
    bus.wrc_grnt = 8'hFF;
    bus.in_valid = 1'b1;
    bus.in_word  = pat(0);
    tick();
    bus.in_word  = pat(1);
    tick();
    #1 chk("r_mid_en", bus.wrc_en, 8'h01);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("r_cmd_ready", bus.cmd_ready, 1);
    chk("r_in_ready", bus.in_ready, 0);
    chk("r_wrc_en", bus.wrc_en, 0);
    chk("r_wrc_addr", bus.wrc_addr, 0);
    chk("r_wrc_word", bus.wrc_word, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_done", bus.done, 0);
    issue_cmd(8'h01, 15'h0100, 16'd1);
    stream_load(15'h0100, 1, 8'h01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
